// File: rtl/return_addr_stack_if.sv
// Return-address stack port bundle: call/return controls in, top/status out.
// master = PC-select side, slave = the stack itself.
interface return_addr_stack_if #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              push;
  logic              pop;
  logic              flush;
  logic              err_clr;
  logic [ADDR_W-1:0] push_data;
  logic [ADDR_W-1:0] top;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, flush, err_clr, push_data,
    input  top, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, flush, err_clr, push_data,
    output top, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_addr_stack.sv
// Return-address stack: push on call, pop on return, sticky error flags.
// Ports: clk, rst (async active-low), bus (slave: push/pop/flush/err_clr/
// push_data in; top/count/empty/full/overflow/underflow out).
// RAS_CIRCULAR_EN: push on full overwrites the oldest entry instead of
// being dropped.
module return_addr_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input logic                clk,
  input logic                rst,
  return_addr_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     tp_q, tp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              we;
  logic [PW-1:0]     waddr;
  logic              ovf_ev;
  logic              unf_ev;
  logic              is_empty;
  logic              is_full;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CW'(DEPTH));

  always_comb begin
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    we     = 1'b0;
    waddr  = tp_q + PW'(1);
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    if (bus.flush) begin
      tp_d  = '0;
      cnt_d = '0;
    end else if (bus.push && bus.pop) begin
      if (!is_empty) begin
        // Return then call in one cycle: swap the top in place.
        we    = 1'b1;
        waddr = tp_q;
      end else begin
        unf_ev = 1'b1;
        we     = 1'b1;
        tp_d   = tp_q + PW'(1);
        cnt_d  = CW'(1);
      end
    end else if (bus.push) begin
      if (!is_full) begin
        we    = 1'b1;
        tp_d  = tp_q + PW'(1);
        cnt_d = cnt_q + CW'(1);
      end else begin
        ovf_ev = 1'b1;
`ifdef RAS_CIRCULAR_EN
        // tp wraps onto the oldest slot; count stays saturated.
        we   = 1'b1;
        tp_d = tp_q + PW'(1);
`endif
      end
    end else if (bus.pop) begin
      if (!is_empty) begin
        tp_d  = tp_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end else begin
        unf_ev = 1'b1;
      end
    end
    // A fresh error in the clearing cycle must stay visible.
    ovf_d = (ovf_q && !bus.err_clr) || ovf_ev;
    unf_d = (unf_q && !bus.err_clr) || unf_ev;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= bus.push_data;
    end
  end

  assign bus.top       = is_empty ? '0 : mem_q[tp_q];
  assign bus.count     = cnt_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_return_addr_stack.sv
// Scoreboard bench for return_addr_stack (ADDR_W=12, DEPTH=4).
// Stimulus queues expected values; a monitor pops and compares on sample.
module tb_return_addr_stack;
  localparam int AW = 12;
  localparam int DP = 4;

  localparam int S_TOP = 0;
  localparam int S_CNT = 1;
  localparam int S_EMP = 2;
  localparam int S_FUL = 3;
  localparam int S_OVF = 4;
  localparam int S_UNF = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int vecs = 0;
  int bad  = 0;

  item_t sbq[$];
  event  smp;

  return_addr_stack_if #(.ADDR_W(AW), .DEPTH(DP)) bus();

  return_addr_stack #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] act(int sel);
    logic [15:0] v;
    v = 16'hxxxx;
    case (sel)
      S_TOP:   v = 16'(bus.top);
      S_CNT:   v = 16'(bus.count);
      S_EMP:   v = 16'(bus.empty);
      S_FUL:   v = 16'(bus.full);
      S_OVF:   v = 16'(bus.overflow);
      S_UNF:   v = 16'(bus.underflow);
      default: v = 16'hxxxx;
    endcase
    return v;
  endfunction

  initial begin : monitor
    item_t it;
    logic [15:0] a;
    forever begin
      @(smp);
      while (sbq.size() > 0) begin
        it = sbq.pop_front();
        a  = act(it.sel);
        vecs++;
        if (a !== it.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", it.name, a, it.exp);
        end
      end
    end
  end

  task automatic chk(string name, int sel, logic [15:0] exp);
    item_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    sbq.push_back(it);
  endtask

  task automatic sample();
    ->smp;
    #1;
  endtask

  task automatic idle();
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.flush     = 1'b0;
    bus.err_clr   = 1'b0;
    bus.push_data = '0;
  endtask

  task automatic cyc(logic pu, logic po, logic fl, logic ec,
                     logic [AW-1:0] d);
    bus.push      = pu;
    bus.pop       = po;
    bus.flush     = fl;
    bus.err_clr   = ec;
    bus.push_data = d;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(logic [AW-1:0] d);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, d);
  endtask

  // Return target must be valid while pop is asserted, before the edge.
  task automatic pop_chk(string name, logic [AW-1:0] exp);
    bus.pop = 1'b1;
    #1;
    chk(name, S_TOP, 16'(exp));
    sample();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [AW-1:0] ovf_pops [4];
`ifdef RAS_CIRCULAR_EN
    ovf_pops = '{12'hA05, 12'hA04, 12'hA03, 12'hA02};
`else
    ovf_pops = '{12'hA04, 12'hA03, 12'hA02, 12'hA01};
`endif
    idle();
    #2;
    chk("rst_top", S_TOP, 16'h0);
    chk("rst_cnt", S_CNT, 16'd0);
    chk("rst_emp", S_EMP, 16'd1);
    chk("rst_ful", S_FUL, 16'd0);
    chk("rst_ovf", S_OVF, 16'd0);
    chk("rst_unf", S_UNF, 16'd0);
    sample();
    @(negedge clk);
    rst = 1'b1;

    push(12'h010);
    push(12'h020);
    chk("pre_rst_cnt", S_CNT, 16'd2);
    chk("pre_rst_top", S_TOP, 16'h020);
    sample();
    rst = 1'b0;
    #1;
    chk("mid_rst_cnt", S_CNT, 16'd0);
    chk("mid_rst_top", S_TOP, 16'h000);
    chk("mid_rst_emp", S_EMP, 16'd1);
    sample();
    rst = 1'b1;

    push(12'h100);
    push(12'h200);
    chk("push1_top", S_TOP, 16'h200);
    sample();
    push(12'h300);
    pop_chk("lifo_pop0", 12'h300);
    pop_chk("lifo_pop1", 12'h200);
    pop_chk("lifo_pop2", 12'h100);
    chk("lifo_emp", S_EMP, 16'd1);
    chk("lifo_unf", S_UNF, 16'd0);
    sample();

    for (int i = 1; i <= 5; i++) push(AW'(12'hA00 + i));
    chk("ovf_flag", S_OVF, 16'd1);
    chk("ovf_cnt", S_CNT, 16'd4);
    chk("ovf_full", S_FUL, 16'd1);
    sample();
    for (int i = 0; i < 4; i++) pop_chk($sformatf("ovf_pop%0d", i), ovf_pops[i]);
    chk("ovf_unf_pre", S_UNF, 16'd0);
    sample();
    pop_chk("ovf_pop4", 12'h000);
    chk("ovf_unf", S_UNF, 16'd1);
    chk("ovf_emp", S_EMP, 16'd1);
    sample();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("clr_ovf", S_OVF, 16'd0);
    chk("clr_unf", S_UNF, 16'd0);
    sample();

    push(12'h111);
    push(12'h222);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'h333);
    chk("swap_cnt", S_CNT, 16'd2);
    chk("swap_top", S_TOP, 16'h333);
    sample();
    pop_chk("swap_pop", 12'h333);
    chk("swap_next", S_TOP, 16'h111);
    chk("swap_cnt1", S_CNT, 16'd1);
    sample();
    pop_chk("swap_last", 12'h111);

    cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'h055);
    chk("epp_cnt", S_CNT, 16'd1);
    chk("epp_top", S_TOP, 16'h055);
    chk("epp_unf", S_UNF, 16'd1);
    sample();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, '0);
    chk("clr_pop_unf", S_UNF, 16'd0);
    chk("clr_pop_cnt", S_CNT, 16'd0);
    sample();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, '0);
    chk("clr_win_unf", S_UNF, 16'd1);
    sample();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);

    for (int i = 0; i < 4; i++) push(AW'(12'h400 + i));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'h4FF);
    chk("fswap_ovf", S_OVF, 16'd0);
    chk("fswap_cnt", S_CNT, 16'd4);
    chk("fswap_top", S_TOP, 16'h4FF);
    sample();
    pop_chk("fswap_pop", 12'h4FF);
    chk("fswap_next", S_TOP, 16'h402);
    sample();

    cyc(1'b1, 1'b0, 1'b1, 1'b0, 12'h777);
    chk("flush_cnt", S_CNT, 16'd0);
    chk("flush_emp", S_EMP, 16'd1);
    chk("flush_top", S_TOP, 16'h000);
    chk("flush_unf", S_UNF, 16'd0);
    sample();
    push(12'h888);
    chk("post_flush_top", S_TOP, 16'h888);
    chk("post_flush_cnt", S_CNT, 16'd1);
    sample();

    #5;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule

// File: doc/return_addr_stack.md
# return_addr_stack

Parametrised return-address stack for the pipelined core: stores subroutine return PCs on push (call) and supplies the top entry to the PC-select mux on pop (return). It replaces the fixed-size call stack with configurable address width and depth. It adds full/empty status, a live entry count, and sticky overflow/underflow error flags. It also defines behaviour for simultaneous push/pop, for flush, and, optionally, for circular overwrite on overflow.

## Interface
Parameters:
- ADDR_W, 12, width of a stored return address (PC width)
- DEPTH, 8, number of entries; must be a power of two, ≥ 2

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- push  in  1  write push_data as new top entry
- pop  in  1  remove top entry
- flush  in  1  discard all entries (pipeline redirect/kill)
- err_clr  in  1  clear sticky overflow/underflow
- push_data  in  ADDR_W  return address to store (PC+1 of call)
- top  out  ADDR_W  current top-of-stack; 0 when empty
- count  out  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a push arrived while full without pop
- underflow  out  1  sticky: a pop arrived while empty

## Operation
- Storage: DEPTH×ADDR_W register array, top pointer tp (log2 DEPTH bits, wraps modulo DEPTH), counter count.
- top = mem[tp] when count > 0, else 0. It is a combinational read of registered state.
- Per-edge priority: flush > (push, pop) > idle.
- flush: count ← 0, tp ← 0. Array contents are don't-care. err_clr is still honoured in the same cycle. push and pop are ignored.
- push only, not full: tp ← tp+1, mem[tp+1] ← push_data, count+1.
- push only, full: behaviour selected by the macro (see Configuration). overflow ← 1 in both modes.
- pop only, count > 0: tp ← tp−1, count−1.
- pop only, empty: no state change; underflow ← 1.
- push and pop together, count > 0: replace top. mem[tp] ← push_data; tp and count unchanged; no flag set, even when full.
- push and pop together, empty: pop is ignored and underflow ← 1. The push proceeds normally and count becomes 1.
- err_clr: overflow ← 0, underflow ← 0. A new error event in the same cycle wins, so the flag reads 1.
- The consumer samples `top` in the same cycle it asserts pop (return target). The next entry appears after the edge.

## Timing
- Reset (rst low, asynchronous): count=0, tp=0, top=0, empty=1, full=0, overflow=0, underflow=0. The array is not reset.
- Release of rst is synchronous to clk, and the first operation is accepted on the first rising edge with rst high.
- Push-to-top latency: 1 edge. After the edge that pushes A, top=A in the same cycle.
- Pop: top is valid combinationally before the edge. count, empty, full and top update 1 edge later.
- All status outputs derive from registered state. No input-to-output combinational path except none: top, count and flags depend only on registers.
- Back-to-back push/pop every cycle is supported with no bubbles.

## Configuration
- RAS_CIRCULAR_EN defined: push on full writes mem[tp+1 mod DEPTH] and sets tp ← tp+1. This overwrites the oldest entry. count stays DEPTH and full stays 1. The most recent DEPTH addresses remain retrievable in LIFO order.
- RAS_CIRCULAR_EN undefined: push on full is dropped. tp, count and the array are unchanged, and the existing DEPTH entries are preserved.

## Test plan
- Reset mid-operation: ADDR_W=12, DEPTH=4. Push 0x010 and 0x020, then assert rst low between edges. Required: count=0, top=0x000 and empty=1 immediately, without waiting for a clk edge.
- LIFO order: push 0x100, 0x200, 0x300. Then pop 3×, sampling top each pop cycle. Required: sampled 0x300, 0x200, 0x100; final empty=1, underflow=0.
- Overflow, DEPTH=4: push 0xA01..0xA05, then pop 5×.
  - Without macro: overflow=1, count=4, pops yield 0xA04, 0xA03, 0xA02, 0xA01, and the fifth pop sets underflow=1.
  - With RAS_CIRCULAR_EN: pops yield 0xA05, 0xA04, 0xA03, 0xA02, then underflow=1.
- Simultaneous push+pop: with stack holding 0x111, 0x222 (top), assert push=1, pop=1, push_data=0x333. Required: count stays 2, top=0x333 next cycle, and a following pop exposes 0x111.
- Empty push+pop and error clearing:
  - From empty, assert push=1, pop=1, push_data=0x055. Required: count=1, top=0x055, underflow=1.
  - Then assert err_clr=1 with pop=1 while count=1. Required: underflow=0 and count=0.
  - Next cycle, assert err_clr=1 with pop=1 while empty. Required: underflow=1 (the new event wins over clear).
- Flush priority: with 3 entries, assert flush=1, push=1, push_data=0x777. Required: count=0, empty=1, top=0; the push is discarded.
